// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the mini-CPU control path.
//   - opcode constants LOAD..DISPLAY
//   - state encoding of the sequencer FSM (also exported on state_dbg)
//   - instruction field bundle and strobe bundle
//   - opcode_writes_ram(): opcodes whose result goes through the ALU into RAM
package cpu_pkg;

    localparam logic [2:0] OP_LOAD    = 3'b000;
    localparam logic [2:0] OP_ADD     = 3'b001;
    localparam logic [2:0] OP_ADDI    = 3'b010;
    localparam logic [2:0] OP_SUB     = 3'b011;
    localparam logic [2:0] OP_SUBI    = 3'b100;
    localparam logic [2:0] OP_MUL     = 3'b101;
    localparam logic [2:0] OP_CLEAR   = 3'b110;
    localparam logic [2:0] OP_DISPLAY = 3'b111;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_INIT      = 3'd1,
        ST_IDLE      = 3'd2,
        ST_DECODE    = 3'd3,
        ST_EXECUTE   = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_SHOW      = 3'd6
    } state_e;

    typedef struct packed {
        logic [2:0] opcode;
        logic [3:0] addr1;
        logic [3:0] addr2;
        logic [6:0] addr3_imm;
    } instr_t;

    typedef struct packed {
        logic rd;
        logic wr;
        logic clr;
        logic alu;
        logic lcd;
    } strobe_t;

    // LOAD..MUL run through the ALU and end with a RAM write.
    function automatic logic opcode_writes_ram(input logic [2:0] op);
        return (op <= OP_MUL);
    endfunction

endpackage

// File: rtl/btn_release_detect.sv
// btn_release_detect: turns an asynchronous active-low pushbutton into a
// one-cycle pulse on release (0->1 of the synchronized level).
//   clk, rst_n  : clock, async active-low reset
//   btn_n       : raw button pin, pressed = 0
//   rel_pulse   : one-cycle release event, SYNC_STAGES+1 cycles after the pin
//                 rises (plus DEBOUNCE_CYCLES with CPU_SEQ_DEBOUNCE_EN)
// Optional: `define CPU_SEQ_DEBOUNCE_EN adds a stable-level debounce filter.
module btn_release_detect #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic rel_pulse
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be 2..4");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
        $error("DEBOUNCE_CYCLES must be >= 1");
    end

    // Trackers reset to "released" so a button held through reset is seen
    // as a fresh press, never as a release.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n};
    end
    assign sync_lvl = sync_q[SYNC_STAGES-1];

    logic lvl_db;
`ifdef CPU_SEQ_DEBOUNCE_EN
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DBW-1:0] db_cnt;

    // Level only follows the synchronizer after DEBOUNCE_CYCLES consecutive
    // cycles of disagreement; any bounce back restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt <= '0;
            lvl_db <= 1'b1;
        end else if (sync_lvl == lvl_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt <= '0;
            lvl_db <= sync_lvl;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end
`else
    assign lvl_db = sync_lvl;
`endif

    logic lvl_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q     <= 1'b1;
            rel_pulse <= 1'b0;
        end else begin
            lvl_q     <= lvl_db;
            rel_pulse <= lvl_db & ~lvl_q;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: central control FSM of the mini-CPU.
//   Inputs : clk, rst_n (async, active-low), ligar/enviar pushbuttons
//            (async, active-low), instruction switches (opcode_in, addr1_in,
//            addr2_in, addr3_imm_in), alu_done, lcd_busy.
//   Outputs: latched fields (*_q), one-cycle strobes ram_rd_en, ram_wr_en,
//            ram_clr, alu_start, lcd_start; lcd_show_ram display select,
//            cpu_on, sticky ALU-timeout flag erro, state_dbg.
//   All outputs are registered; every strobe covers the first cycle of its
//   state. Optional `define CPU_SEQ_DEBOUNCE_EN enables button debouncing.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int ALU_TIMEOUT     = 64,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ligar,
    input  logic       enviar,
    input  logic [2:0] opcode_in,
    input  logic [3:0] addr1_in,
    input  logic [3:0] addr2_in,
    input  logic [6:0] addr3_imm_in,
    input  logic       alu_done,
    input  logic       lcd_busy,
    output logic [2:0] opcode_q,
    output logic [3:0] addr1_q,
    output logic [3:0] addr2_q,
    output logic [6:0] addr3_imm_q,
    output logic       ram_rd_en,
    output logic       ram_wr_en,
    output logic       ram_clr,
    output logic       alu_start,
    output logic       lcd_start,
    output logic       lcd_show_ram,
    output logic       cpu_on,
    output logic       erro,
    output logic [2:0] state_dbg
);

    localparam int CNT_W = $clog2(ALU_TIMEOUT + 1);

    // Button events: index 0 = ligar, index 1 = enviar.
    logic [1:0] evt;
    btn_release_detect #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn [1:0] (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_n    ({enviar, ligar}),
        .rel_pulse(evt)
    );

    logic ligar_evt, enviar_evt;
    assign ligar_evt  = evt[0];
    assign enviar_evt = evt[1] & ~evt[0];

    state_e           state, next_state;
    instr_t           instr_q, instr_in;
    strobe_t          stb_q, stb_d;
    logic             show_ram_q, show_ram_d;
    logic             erro_q, erro_d;
    logic             cpu_on_q;
    logic             latch_en;
    logic [CNT_W-1:0] alu_cnt, alu_cnt_d;
    logic             alu_timeout;

    assign instr_in = '{opcode: opcode_in, addr1: addr1_in,
                        addr2: addr2_in, addr3_imm: addr3_imm_in};

    // alu_cnt counts completed EXECUTE cycles; the last allowed cycle is
    // ALU_TIMEOUT, and alu_done in that cycle still wins.
    assign alu_timeout = (state == ST_EXECUTE) && !alu_done &&
                         (alu_cnt == CNT_W'(ALU_TIMEOUT - 1));

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_OFF;
            instr_q    <= '0;
            stb_q      <= '0;
            show_ram_q <= 1'b0;
            erro_q     <= 1'b0;
            cpu_on_q   <= 1'b0;
            alu_cnt    <= '0;
        end else begin
            state      <= next_state;
            stb_q      <= stb_d;
            show_ram_q <= show_ram_d;
            erro_q     <= erro_d;
            cpu_on_q   <= (next_state != ST_OFF);
            alu_cnt    <= alu_cnt_d;
            if (latch_en) instr_q <= instr_in;
        end
    end

    // Next state
    always_comb begin
        next_state = state;
        if (state != ST_OFF && ligar_evt) begin
            next_state = ST_OFF;
        end else begin
            unique case (state)
                ST_OFF:       if (ligar_evt) next_state = ST_INIT;
                ST_INIT:      next_state = ST_IDLE;
                ST_IDLE:      if (enviar_evt) next_state = ST_DECODE;
                ST_DECODE: begin
                    if (opcode_writes_ram(instr_q.opcode))  next_state = ST_EXECUTE;
                    else if (instr_q.opcode == OP_CLEAR)    next_state = ST_WRITEBACK;
                    else                                    next_state = ST_SHOW;
                end
                ST_EXECUTE: begin
                    if (alu_done)         next_state = ST_WRITEBACK;
                    else if (alu_timeout) next_state = ST_IDLE;
                end
                ST_WRITEBACK: next_state = ST_SHOW;
                // First SHOW cycle is marked by the lcd_start register; the
                // LCD has not had time to raise busy yet.
                ST_SHOW:      if (!stb_q.lcd && !lcd_busy) next_state = ST_IDLE;
                default:      next_state = ST_OFF;
            endcase
        end
    end

    // Output / datapath next values
    always_comb begin
        logic entering;
        entering   = (next_state != state);
        stb_d      = '0;
        erro_d     = erro_q;
        latch_en   = (state == ST_IDLE) && (next_state == ST_DECODE);
        alu_cnt_d  = '0;
        show_ram_d = 1'b0;

        if (entering) begin
            unique case (next_state)
                ST_INIT:      stb_d.clr = 1'b1;
                ST_DECODE:    stb_d.rd  = 1'b1;
                ST_EXECUTE:   stb_d.alu = 1'b1;
                ST_WRITEBACK: begin
                    if (opcode_writes_ram(instr_q.opcode)) stb_d.wr  = 1'b1;
                    else                                   stb_d.clr = 1'b1;
                end
                ST_SHOW:      stb_d.lcd = 1'b1;
                default:      stb_d = '0;
            endcase
        end

        // DISPLAY reaches SHOW straight from DECODE; everything else via
        // WRITEBACK shows the ALU result.
        if (next_state == ST_SHOW)
            show_ram_d = entering ? (state == ST_DECODE) : show_ram_q;

        if (latch_en) erro_d = 1'b0;
        if (alu_timeout && next_state == ST_IDLE) erro_d = 1'b1;

        if (state == ST_EXECUTE && next_state == ST_EXECUTE)
            alu_cnt_d = alu_cnt + 1'b1;
    end

    assign opcode_q     = instr_q.opcode;
    assign addr1_q      = instr_q.addr1;
    assign addr2_q      = instr_q.addr2;
    assign addr3_imm_q  = instr_q.addr3_imm;
    assign ram_rd_en    = stb_q.rd;
    assign ram_wr_en    = stb_q.wr;
    assign ram_clr      = stb_q.clr;
    assign alu_start    = stb_q.alu;
    assign lcd_start    = stb_q.lcd;
    assign lcd_show_ram = show_ram_q;
    assign cpu_on       = cpu_on_q;
    assign erro         = erro_q;
    assign state_dbg    = state;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

    logic       clk = 1'b0, rst_n = 1'b0, ligar = 1'b1, enviar = 1'b1;
    logic [2:0] opcode_in = '0;
    logic [3:0] addr1_in = '0, addr2_in = '0;
    logic [6:0] addr3_imm_in = '0;
    logic       alu_done = 1'b0, lcd_busy = 1'b0;
    logic [2:0] opcode_q, state_dbg;
    logic [3:0] addr1_q, addr2_q;
    logic [6:0] addr3_imm_q;
    logic       ram_rd_en, ram_wr_en, ram_clr, alu_start, lcd_start;
    logic       lcd_show_ram, cpu_on, erro;

    cpu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .ligar(ligar), .enviar(enviar),
        .opcode_in(opcode_in), .addr1_in(addr1_in), .addr2_in(addr2_in),
        .addr3_imm_in(addr3_imm_in), .alu_done(alu_done), .lcd_busy(lcd_busy),
        .opcode_q(opcode_q), .addr1_q(addr1_q), .addr2_q(addr2_q),
        .addr3_imm_q(addr3_imm_q), .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en),
        .ram_clr(ram_clr), .alu_start(alu_start), .lcd_start(lcd_start),
        .lcd_show_ram(lcd_show_ram), .cpu_on(cpu_on), .erro(erro),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Strobe event codes seen by the scoreboard
    localparam logic [3:0] EV_CLR = 4'd1, EV_RD = 4'd2, EV_WR = 4'd3,
                           EV_ALU = 4'd4, EV_L0 = 4'd5, EV_L1 = 4'd6, EV_NONE = 4'd0;

    int errors = 0, checks = 0;
    int alu_delay = -1, lcd_hold = 3, exec_len = 0;
    logic show_ref = 1'b0;
    logic [3:0] exp_q[$];

    typedef struct {
        logic [2:0] op;
        logic [3:0] a1, a2;
        logic [6:0] a3;
        int         dly;
        int         nseq;
        logic [3:0][3:0] seq;
        logic       erro;
        int         exec;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(logic [2:0] op, logic [3:0] a1, logic [3:0] a2,
                                logic [6:0] a3, int dly, int nseq,
                                logic [3:0] s0, logic [3:0] s1, logic [3:0] s2,
                                logic [3:0] s3, logic er, int ex);
        vec_t v;
        v.op = op; v.a1 = a1; v.a2 = a2; v.a3 = a3; v.dly = dly; v.nseq = nseq;
        v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2; v.seq[3] = s3;
        v.erro = er; v.exec = ex;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic sb_got(input logic [3:0] got);
        logic [3:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_strobe: got event %0d at t=%0t, expected none", got, $time);
        end else begin
            e = exp_q.pop_front();
            if (e !== got) begin
                errors++;
                $display("FAIL sb_strobe: got event %0d at t=%0t, expected %0d", got, $time, e);
            end
        end
    endtask

    task automatic wait_state(input logic [2:0] tgt, input int maxc, input string nm);
        int n = 0;
        while (state_dbg !== tgt && n < maxc) begin @(negedge clk); n++; end
        checks++;
        if (state_dbg !== tgt) begin
            errors++;
            $display("FAIL %s: state %0d, expected %0d (timeout)", nm, state_dbg, tgt);
        end
    endtask

    task automatic wait_leave(input logic [2:0] st, input int maxc, input string nm);
        int n = 0;
        while (state_dbg === st && n < maxc) begin @(negedge clk); n++; end
        checks++;
        if (state_dbg === st) begin
            errors++;
            $display("FAIL %s: still in state %0d (timeout)", nm, st);
        end
    endtask

    task automatic press(input bit do_l, input bit do_e);
        @(negedge clk);
        if (do_l) ligar = 1'b0;
        if (do_e) enviar = 1'b0;
        repeat (3) @(negedge clk);
        ligar = 1'b1;
        enviar = 1'b1;
    endtask

    task automatic set_sw(input logic [2:0] op, input logic [3:0] a1,
                          input logic [3:0] a2, input logic [6:0] a3);
        opcode_in = op; addr1_in = a1; addr2_in = a2; addr3_imm_in = a3;
    endtask

    task automatic power_on();
        exp_q.push_back(EV_CLR);
        press(1, 0);
        wait_state(3'd2, 20, "power_on_idle");
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        set_sw(v.op, v.a1, v.a2, v.a3);
        alu_delay = v.dly;
        for (int k = 0; k < v.nseq; k++) exp_q.push_back(v.seq[k]);
        press(0, 1);
        wait_leave(3'd2, 10, "leave_idle");
        set_sw(~v.op, ~v.a1, ~v.a2, ~v.a3);
        wait_state(3'd2, 200, "back_idle");
        repeat (2) @(negedge clk);
        chk($sformatf("fields[%0d]", idx), {opcode_q, addr1_q, addr2_q, addr3_imm_q},
            {v.op, v.a1, v.a2, v.a3});
        chk($sformatf("erro[%0d]", idx), erro, v.erro);
        chk($sformatf("exec_len[%0d]", idx), exec_len, v.exec);
        chk($sformatf("sb_drain[%0d]", idx), exp_q.size(), 0);
    endtask

    // Scoreboard monitor: every strobe cycle must match the next expected event
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (ram_clr)   sb_got(EV_CLR);
            if (ram_rd_en) sb_got(EV_RD);
            if (ram_wr_en) sb_got(EV_WR);
            if (alu_start) sb_got(EV_ALU);
            if (lcd_start) begin
                sb_got(lcd_show_ram ? EV_L1 : EV_L0);
                show_ref = lcd_show_ram;
            end else if (state_dbg == 3'd6) begin
                chk("show_ram_hold", lcd_show_ram, show_ref);
            end
            if (state_dbg == 3'd3)      exec_len = 0;
            else if (state_dbg == 3'd4) exec_len++;
        end
    end

    // ALU model: alu_done pulse alu_delay cycles after alu_start (never if < 0)
    initial forever begin
        @(negedge clk);
        if (rst_n && alu_start && alu_delay >= 0) begin
            repeat (alu_delay) @(negedge clk);
            alu_done = 1'b1;
            @(negedge clk);
            alu_done = 1'b0;
        end
    end

    // LCD model: busy for lcd_hold cycles after lcd_start
    initial forever begin
        @(negedge clk);
        if (rst_n && lcd_start) begin
            lcd_busy = 1'b1;
            repeat (lcd_hold) @(negedge clk);
            lcd_busy = 1'b0;
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int n;
        vecs[0] = mk(3'b001, 4'd3,  4'd4,  7'b0101000, 3, 4, EV_RD, EV_ALU, EV_WR, EV_L0, 1'b0, 4);
        vecs[1] = mk(3'b110, 4'd1,  4'd2,  7'h7F,      3, 3, EV_RD, EV_CLR, EV_L0, EV_NONE, 1'b0, 0);
        vecs[2] = mk(3'b111, 4'd9,  4'd10, 7'h11,      3, 2, EV_RD, EV_L1, EV_NONE, EV_NONE, 1'b0, 0);
        vecs[3] = mk(3'b010, 4'd5,  4'd6,  7'b1111000, 0, 4, EV_RD, EV_ALU, EV_WR, EV_L0, 1'b0, 1);
        vecs[4] = mk(3'b101, 4'd7,  4'd8,  7'h2A,     -1, 2, EV_RD, EV_ALU, EV_NONE, EV_NONE, 1'b1, 64);
        vecs[5] = mk(3'b000, 4'd15, 4'd0,  7'h40,      1, 4, EV_RD, EV_ALU, EV_WR, EV_L0, 1'b0, 2);
        vecs[6] = mk(3'b011, 4'd2,  4'd3,  7'h05,      2, 4, EV_RD, EV_ALU, EV_WR, EV_L0, 1'b0, 3);
        vecs[7] = mk(3'b100, 4'd12, 4'd13, 7'h33,      5, 4, EV_RD, EV_ALU, EV_WR, EV_L0, 1'b0, 6);

        // Reset state
        #2;
        chk("reset_outputs", {opcode_q, addr1_q, addr2_q, addr3_imm_q, ram_rd_en, ram_wr_en,
                              ram_clr, alu_start, lcd_start, lcd_show_ram, cpu_on, erro}, 0);
        chk("reset_state", state_dbg, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // enviar is ignored while OFF
        press(0, 1);
        repeat (8) @(negedge clk);
        chk("off_ignores_enviar", state_dbg, 0);

        // Power on: release-to-INIT latency is SYNC_STAGES+1 plus the state register
        exp_q.push_back(EV_CLR);
        @(negedge clk); ligar = 1'b0;
        repeat (3) @(negedge clk);
        ligar = 1'b1;
        n = 0;
        while (state_dbg !== 3'd1 && n < 20) begin @(negedge clk); n++; end
        chk("ligar_latency", n, 4);
        wait_state(3'd2, 10, "init_to_idle");
        chk("cpu_on", cpu_on, 1);
        chk("erro_after_on", erro, 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);
        chk("addr3_dest", vecs[0].a3[6:3], 4'd5);

        // Power-off during EXECUTE: no write, fields kept
        set_sw(3'b001, 4'd3, 4'd4, 7'b0101000);
        alu_delay = -1;
        exp_q.push_back(EV_RD); exp_q.push_back(EV_ALU);
        press(0, 1);
        wait_state(3'd4, 12, "reach_execute");
        press(1, 0);
        wait_state(3'd0, 8, "poweroff_exec");
        repeat (4) @(negedge clk);
        chk("off_cpu_on", cpu_on, 0);
        chk("off_fields", {opcode_q, addr1_q, addr2_q, addr3_imm_q}, {3'b001, 4'd3, 4'd4, 7'b0101000});
        chk("off_sb_drain", exp_q.size(), 0);
        power_on();

        // Simultaneous ligar+enviar in IDLE: power-off wins, nothing relatched
        set_sw(3'b111, 4'd9, 4'd9, 7'h7F);
        press(1, 1);
        wait_state(3'd0, 10, "simul_off");
        repeat (4) @(negedge clk);
        chk("simul_fields", {opcode_q, addr1_q, addr2_q, addr3_imm_q}, {3'b001, 4'd3, 4'd4, 7'b0101000});
        chk("simul_sb_drain", exp_q.size(), 0);
        power_on();

        // Busy lockout: enviar during SHOW is dropped
        lcd_hold = 15;
        set_sw(3'b111, 4'd6, 4'd7, 7'h12);
        exp_q.push_back(EV_RD); exp_q.push_back(EV_L1);
        press(0, 1);
        wait_state(3'd6, 10, "reach_show");
        press(0, 1);
        wait_state(3'd2, 60, "show_to_idle");
        repeat (15) @(negedge clk);
        chk("lockout_idle", state_dbg, 2);
        chk("lockout_sb_drain", exp_q.size(), 0);
        lcd_hold = 3;

        // Reset mid-instruction
        set_sw(3'b001, 4'd1, 4'd1, 7'h08);
        alu_delay = -1;
        exp_q.push_back(EV_RD); exp_q.push_back(EV_ALU);
        press(0, 1);
        wait_state(3'd4, 12, "reach_execute2");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_state", state_dbg, 0);
        chk("midreset_outputs", {opcode_q, addr1_q, addr2_q, addr3_imm_q, ram_rd_en, ram_wr_en,
                                 ram_clr, alu_start, lcd_start, lcd_show_ram, cpu_on, erro}, 0);
        chk("midreset_sb_drain", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_reset_off", state_dbg, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
